// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler: full linear convolution of a streamed frame with TAPS coefficients,
// sequenced over one shared multiply-accumulate.
module fir_tap_scheduler #(
    parameter int TAPS  = 20,
    parameter int DW    = 16,
    parameter int AW    = 5,
    parameter int ACC_W = 40,
    parameter int SHIFT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   frame_len,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [DW-1:0] coef_wdata,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);
    localparam int PW = $clog2(TAPS);
    localparam int CW = $clog2(TAPS + 1);
    localparam logic [PW-1:0] K_LAST = PW'(TAPS - 1);
    localparam logic [PW-1:0] K_MOD  = PW'(TAPS);
    localparam logic [CW-1:0] W_FULL = CW'(TAPS);
    localparam logic [AW:0]   A_LIM  = (AW + 1)'(TAPS);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACCEPT, MAC, SAT, OUT, FLUSH} state_t;

    state_t state, nxt;
    logic signed [DW-1:0] coef [TAPS];
    logic signed [DW-1:0] smp [TAPS];
    logic [PW-1:0] wp, k, idx;
    logic [CW-1:0] wc;
    logic [15:0] n, sc;
    logic [16:0] oc, last_oc;
    logic signed [ACC_W-1:0] acc, term, sh;
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0] sat_val;
    logic wr;

    assign in_ready = state == ACCEPT;
    assign busy     = state != IDLE;
    assign wr       = state == FLUSH || (state == ACCEPT && in_valid);
    assign last_oc  = {1'b0, n} + 17'(TAPS - 2);

    // wc counts buffer writes this frame, so taps reaching older slots see zero, not stale data
    always_comb begin
        idx     = wp >= k ? wp - k : wp + K_MOD - k;
        prod    = coef[k] * smp[idx];
        term    = CW'(k) < wc ? ACC_W'(prod) : '0;
        sh      = acc >>> SHIFT;
        sat_val = sh > MAXV ? MAXV[DW-1:0] : sh < MINV ? MINV[DW-1:0] : sh[DW-1:0];
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start && frame_len != 16'd0 ? ACCEPT : IDLE;
            ACCEPT:  nxt = in_valid ? MAC : ACCEPT;
            FLUSH:   nxt = MAC;
            MAC:     nxt = k == K_LAST ? SAT : MAC;
            SAT:     nxt = OUT;
            OUT:     nxt = !out_ready ? OUT : out_last ? IDLE : sc < n ? ACCEPT : FLUSH;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Coefficient and sample storage are deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && coef_we && {1'b0, coef_addr} < A_LIM)
            coef[coef_addr[PW-1:0]] <= coef_wdata;
        if (!rst && wr)
            smp[wp] <= state == FLUSH ? '0 : in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            wp        <= '0;
            k         <= '0;
            wc        <= '0;
            n         <= '0;
            sc        <= '0;
            oc        <= '0;
            acc       <= '0;
        end else begin
            done <= 1'b0;
            if (wr) begin
                wc  <= wc == W_FULL ? wc : wc + CW'(1);
                acc <= '0;
            end
            case (state)
                IDLE: if (start) begin
                    done <= frame_len == 16'd0;
                    n    <= frame_len != 16'd0 ? frame_len : n;
                    sc   <= '0;
                    oc   <= '0;
                    wc   <= '0;
                end
                ACCEPT: if (in_valid) sc <= sc + 16'd1;
                MAC: begin
                    acc <= acc + term;
                    k   <= k == K_LAST ? '0 : k + PW'(1);
                    if (k == K_LAST) wp <= wp == K_LAST ? '0 : wp + PW'(1);
                end
                SAT: begin
                    out_data  <= sat_val;
                    out_valid <= 1'b1;
                    out_last  <= oc == last_oc;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    oc        <= oc + 17'd1;
                    done      <= out_last;
                end
                default: ;
            endcase
        end
    end
endmodule
